// File: rtl/debounce_multi_if.sv
// Bundle of the sample tick, raw inputs and debounced outputs of debounce_multi.
// The slave side is the debouncer; the master side is whoever drives the raw
// inputs and consumes the debounced level and pulses.
interface debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic                sample_en;
    logic [CHANNELS-1:0] sig_in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] hold;
    logic                any_change;

    modport master (
        output sample_en, sig_in,
        input  level, rise, fall, hold, any_change
    );

    modport slave (
        input  sample_en, sig_in,
        output level, rise, fall, hold, any_change
    );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel counter-based debouncer with per-channel synchroniser,
// programmable stability window, sample-rate enable, rise/fall pulses and a
// long-press hold pulse. Every output comes from a register (any_change is an
// OR of registered pulses), so raw inputs never reach an output combinationally.
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_WIDTH     = 16,
    parameter int STABLE_CYCLES = 1000,
    parameter int HOLD_WIDTH    = 24,
    parameter int HOLD_CYCLES   = 500000
) (
    input  logic            clk,
    input  logic            rst,
    debounce_multi_if.slave dbIf
);

    localparam logic [CNT_WIDTH-1:0]  STABLE_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST   = HOLD_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX    = HOLD_WIDTH'(HOLD_CYCLES);

    logic [CHANNELS-1:0] levelVec;
    logic [CHANNELS-1:0] riseVec;
    logic [CHANNELS-1:0] fallVec;
    logic [CHANNELS-1:0] holdVec;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic [CNT_WIDTH-1:0]   stableCnt_q, stableCnt_d;
        logic [HOLD_WIDTH-1:0]  holdCnt_q, holdCnt_d;
        logic                   level_q, level_d;
        logic                   rise_q, rise_d;
        logic                   fall_q, fall_d;
        logic                   hold_q, hold_d;
        logic                   syncOut;

        assign syncOut = sync_q[SYNC_STAGES-1];

        // Next state: shift the synchroniser, run the stability window against
        // the current level, and count sampled ticks spent at level 1.
        always_comb begin
            sync_d      = {sync_q[SYNC_STAGES-2:0], dbIf.sig_in[ch]};
            stableCnt_d = stableCnt_q;
            holdCnt_d   = holdCnt_q;
            level_d     = level_q;
            rise_d      = 1'b0;
            fall_d      = 1'b0;
            hold_d      = 1'b0;

            if (syncOut == level_q) begin
                stableCnt_d = '0;
            end else if (dbIf.sample_en) begin
                if (stableCnt_q == STABLE_LAST) begin
                    level_d     = ~level_q;
                    stableCnt_d = '0;
                    rise_d      = ~level_q;
                    fall_d      = level_q;
                end else begin
                    stableCnt_d = stableCnt_q + 1'b1;
                end
            end

            if (level_q && !level_d) begin
                holdCnt_d = '0;
            end else if (level_q && dbIf.sample_en && (holdCnt_q != HOLD_MAX)) begin
                holdCnt_d = holdCnt_q + 1'b1;
                hold_d    = (holdCnt_q == HOLD_LAST);
            end
        end

        // State register; reset wins over every other event.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q      <= '0;
                stableCnt_q <= '0;
                holdCnt_q   <= '0;
                level_q     <= 1'b0;
                rise_q      <= 1'b0;
                fall_q      <= 1'b0;
                hold_q      <= 1'b0;
            end else begin
                sync_q      <= sync_d;
                stableCnt_q <= stableCnt_d;
                holdCnt_q   <= holdCnt_d;
                level_q     <= level_d;
                rise_q      <= rise_d;
                fall_q      <= fall_d;
                hold_q      <= hold_d;
            end
        end

        assign levelVec[ch] = level_q;
        assign riseVec[ch]  = rise_q;
        assign fallVec[ch]  = fall_q;
        assign holdVec[ch]  = hold_q;
    end

    assign dbIf.level      = levelVec;
    assign dbIf.rise       = riseVec;
    assign dbIf.fall       = fallVec;
    assign dbIf.hold       = holdVec;
    assign dbIf.any_change = |(riseVec | fallVec);

endmodule

// File: tb/tb_debounce_multi.sv
// Testbench for debounce_multi: directed scenarios followed by a random phase,
// every cycle compared against a cycle-history reference model.
module tb_debounce_multi;

    localparam int CH     = 2;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLDC  = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    debounce_multi_if #(.CHANNELS(CH)) dbIf ();

    debounce_multi #(
        .CHANNELS(CH),
        .SYNC_STAGES(SYNC),
        .CNT_WIDTH(16),
        .STABLE_CYCLES(STABLE),
        .HOLD_WIDTH(24),
        .HOLD_CYCLES(HOLDC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dbIf(dbIf.slave)
    );

    int testsRun = 0;
    int failCount = 0;

    // Reference model state: raw input history plus per-channel counts of
    // consecutive sampled mismatches and sampled ticks spent high.
    logic [CH-1:0] hist[$];
    int            mismatchRun[CH];
    int            highTicks[CH];
    logic [CH-1:0] mLevel, mRise, mFall, mHold;

    task automatic modelEdge();
        logic [CH-1:0] s;
        logic          wasHigh;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < SYNC; k++) hist.push_back('0);
            for (int c = 0; c < CH; c++) begin
                mismatchRun[c] = 0;
                highTicks[c]   = 0;
            end
            mLevel = '0; mRise = '0; mFall = '0; mHold = '0;
            return;
        end
        s = hist[hist.size() - SYNC];
        hist.push_back(dbIf.sig_in);
        if (hist.size() > 8) void'(hist.pop_front());
        for (int c = 0; c < CH; c++) begin
            mRise[c] = 1'b0;
            mFall[c] = 1'b0;
            mHold[c] = 1'b0;
            wasHigh  = mLevel[c];
            if (s[c] == mLevel[c]) begin
                mismatchRun[c] = 0;
            end else if (dbIf.sample_en) begin
                mismatchRun[c]++;
                if (mismatchRun[c] == STABLE) begin
                    mLevel[c]      = ~mLevel[c];
                    mismatchRun[c] = 0;
                    if (mLevel[c]) mRise[c] = 1'b1;
                    else           mFall[c] = 1'b1;
                end
            end
            if (wasHigh && !mLevel[c]) begin
                highTicks[c] = 0;
            end else if (wasHigh && dbIf.sample_en && highTicks[c] < HOLDC) begin
                highTicks[c]++;
                if (highTicks[c] == HOLDC) mHold[c] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic compareAll();
        checkOutput("level", dbIf.level, mLevel);
        checkOutput("rise", dbIf.rise, mRise);
        checkOutput("fall", dbIf.fall, mFall);
        checkOutput("hold", dbIf.hold, mHold);
        checkOutput("any_change", CH'(dbIf.any_change), CH'(|(mRise | mFall)));
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare.
    task automatic applyStimulus(input logic r, input logic en, input logic [CH-1:0] sig);
        rst            = r;
        dbIf.sample_en = en;
        dbIf.sig_in    = sig;
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic repeatStimulus(input logic [CH-1:0] sig, input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, sig);
    endtask

    int holdPulses;

    initial begin
        dbIf.sample_en = 1'b1;
        dbIf.sig_in    = '0;

        // Reset held with inputs high; nothing may move.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 2'b11);
            checkOutput("reset_level", dbIf.level, 2'b00);
        end
        applyStimulus(1'b0, 1'b1, 2'b00);
        checkOutput("post_reset_pulses", dbIf.rise | dbIf.fall | dbIf.hold, 2'b00);
        repeatStimulus(2'b00, 6);

        // Clean step on channel 0, then release.
        repeatStimulus(2'b01, 10);
        checkOutput("step_level", dbIf.level, 2'b01);
        repeatStimulus(2'b00, 10);

        // Short glitch on channel 0.
        repeatStimulus(2'b01, 3);
        repeatStimulus(2'b00, 8);
        checkOutput("glitch_level", dbIf.level, 2'b00);

        // Bouncing channel 1 settling high.
        for (int k = 0; k < 12; k++) applyStimulus(1'b0, 1'b1, {k[0], 1'b0});
        repeatStimulus(2'b10, 10);
        checkOutput("bounce_level", dbIf.level, 2'b10);
        repeatStimulus(2'b00, 10);

        // Long press with hold, then a short press without hold.
        holdPulses = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0, 1'b1, 2'b01);
            if (dbIf.hold[0]) holdPulses++;
        end
        repeatStimulus(2'b00, 10);
        repeatStimulus(2'b01, 7);
        repeatStimulus(2'b00, 10);
        checkOutput("hold_count", CH'(holdPulses), CH'(1));

        // Slow sample tick with reset landing mid-window.
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, (k % 4) == 0, 2'b01);
        applyStimulus(1'b1, 1'b1, 2'b01);
        for (int k = 0; k < 8; k++) applyStimulus(1'b0, (k % 4) == 0, 2'b00);
        checkOutput("slow_reset_level", dbIf.level, 2'b00);
        for (int k = 0; k < 30; k++) applyStimulus(1'b0, (k % 4) == 0, 2'b01);
        checkOutput("slow_level", dbIf.level, 2'b01);
        for (int k = 0; k < 30; k++) applyStimulus(1'b0, (k % 4) == 0, 2'b00);

        // Random phase: sticky inputs, random tick, rare reset.
        begin
            logic [CH-1:0] sig;
            sig = '0;
            for (int k = 0; k < 600; k++) begin
                for (int c = 0; c < CH; c++)
                    if ($urandom_range(0, 5) == 0) sig[c] = ~sig[c];
                applyStimulus($urandom_range(0, 150) == 0, $urandom_range(0, 3) != 0, sig);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Multi-channel, counter-based debouncer; next generation of the single-bit shift-register debouncer.
- Adds per-channel input synchroniser, a programmable stability window and an external sample-rate enable.
- Adds one-cycle rise and fall pulses, and a long-press (hold) pulse per channel.
- Sits between raw board inputs (buttons, DIP switches, SPI control strobes) and control FSMs, e.g. ping-pong RAM bank select.

Parameters:
- CHANNELS, 4: number of independent input channels (>=1).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- CNT_WIDTH, 16: stability counter width.
- STABLE_CYCLES, 1000: consecutive sample-enabled mismatch cycles required to change level (1..2^CNT_WIDTH-1).
- HOLD_WIDTH, 24: hold counter width.
- HOLD_CYCLES, 500000: sample-enabled cycles at level 1 before the hold pulse (1..2^HOLD_WIDTH-1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  sample-rate tick; tie to 1 to count every clk.
- sig_in  in  CHANNELS  raw asynchronous inputs.
- level  out  CHANNELS  debounced level.
- rise  out  CHANNELS  one-cycle pulse when level goes 0->1.
- fall  out  CHANNELS  one-cycle pulse when level goes 1->0.
- hold  out  CHANNELS  one-cycle pulse after level has been 1 for HOLD_CYCLES ticks.
- any_change  out  1  OR-reduction of (rise | fall), combinational from registered pulses.

Behaviour:
- Reset: rst at a clk edge clears all synchroniser flops, stability counters, hold counters, level, rise, fall and hold to 0.
  - Reset takes priority over every other event, including mid-count.
  - No pulse is emitted on reset entry or exit.
- Synchroniser: s[i] equals sig_in[i] delayed by SYNC_STAGES edges.
  - If sig_in is stable before edge E0, s reflects it after edge E0+SYNC_STAGES-1.
- Stability counter, per channel, all independent. At each edge:
  - If s == level: counter clears to 0, regardless of sample_en.
  - Else if sample_en = 0: counter holds.
  - Else if counter == STABLE_CYCLES-1: level toggles, counter clears, and rise or fall is asserted for exactly that one following cycle.
  - Else: counter increments.
- Latency with sample_en = 1 throughout: level changes at edge E0+SYNC_STAGES+STABLE_CYCLES-1.
  - Any return of s to the current level before then restarts the window from 0.
- Glitch rejection:
  - Pulses shorter than STABLE_CYCLES sample ticks after synchronisation never change level.
  - Such pulses produce no rise, fall or hold.
- Hold counter:
  - While level = 1 and sample_en = 1, the counter increments and saturates at HOLD_CYCLES.
  - The increment that reaches HOLD_CYCLES asserts hold for one cycle. Counting starts at the edge after the rise edge R, so with sample_en = 1 hold is high after edge R+HOLD_CYCLES.
  - Only one hold pulse per press.
  - The counter clears on the edge on which level becomes 0.
  - A fall before HOLD_CYCLES produces no hold.
- Simultaneous events:
  - Channels may change on the same edge; any_change is high whenever at least one rise or fall bit is high.
  - rise and fall are never both high for one channel.
  - hold and fall cannot coincide, because hold requires level = 1 on that edge.
- Widths: counter compares are unsigned; STABLE_CYCLES = 1 gives level = s delayed one edge.
- No combinational path from sig_in to any output.

Test Plan:
Common config: CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=10, sample_en=1 unless stated. E0 is the first edge at which sig_in is stable.
1. Hold rst for 3 cycles with sig_in=2'b11, then release -> level, rise, fall, hold and any_change are all 0 during reset and on the first cycle after it; no pulse.
2. sig_in[0] steps 0->1 at E0 -> level[0]=1 and rise[0]=1 after edge E0+5; rise[0] low after E0+6; channel 1 and fall stay 0; any_change=1 for one cycle.
3. sig_in[0] high for 3 cycles, then low -> level[0] remains 0; no rise, fall or hold.
4. sig_in[1] toggles every cycle for 12 cycles, then settles high at E0 -> no pulses during bounce; level[1] rises after E0+5 with a single rise[1].
5. After the rise at edge R, keep sig_in[0] high 30 cycles, then drop it -> exactly one hold[0] pulse after R+10. fall[0] appears 5 edges after the drop, with no second hold. Then a 7-cycle high press -> rise and fall only, no hold.
6. sample_en high 1-in-4 cycles; sig_in[0] steps high, and rst is asserted after 2 ticks -> no level change or pulse, counters cleared. Repeat the step without rst -> level[0] rises on the 4th sample-enabled cycle with a mismatch.
